// File: rtl/task_3_lat_meas_ctrl.sv
// task_3_lat_meas_ctrl
//   Sequences repeated latency measurements of the task-3 datapath. Each run
//   clears the latency meter, fires one input-enable pulse, then waits for the
//   meter's valid pulse (or a timeout) and captures the reported latency.
//   Min/max/sum are accumulated over i_num_runs runs per batch.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            start a batch (accepted only when idle)
//   i_num_runs         runs per batch, sampled with i_start
//   i_timeout          max WAIT cycles per run, sampled with i_start (0 = none)
//   o_meas_rst         reset pulse to the latency meter
//   o_in_enb           input-enable pulse to the DUT and the meter
//   i_lat_valid/i_lat  meter result, only looked at while waiting
//   o_busy             high whenever not idle
//   o_done             one-cycle pulse at the end of every batch
//   o_timeout_err      sticky timeout flag, cleared by an accepted i_start
//   o_run_cnt          number of captured runs
//   o_lat_min/max/sum  statistics over captured runs (min reads 0 until a capture)
module task_3_lat_meas_ctrl #(
    parameter int DATA_WIDTH        = 8,
    parameter int LAT_SIZE_IN_WIDTH = 3,
    parameter int RUN_W             = 4,
    localparam int LAT_W            = LAT_SIZE_IN_WIDTH * DATA_WIDTH,
    localparam int SUM_W            = LAT_W + RUN_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [RUN_W-1:0] i_num_runs,
    input  logic [LAT_W-1:0] i_timeout,
    output logic             o_meas_rst,
    output logic             o_in_enb,
    input  logic             i_lat_valid,
    input  logic [LAT_W-1:0] i_lat,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout_err,
    output logic [RUN_W-1:0] o_run_cnt,
    output logic [LAT_W-1:0] o_lat_min,
    output logic [LAT_W-1:0] o_lat_max,
    output logic [SUM_W-1:0] o_lat_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FIRE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [RUN_W-1:0]   num_runs_r;
    logic [LAT_W-1:0]   timeout_r;
    logic [LAT_W-1:0]   timer;
    logic [RUN_W-1:0]   run_cnt;
    logic [LAT_W-1:0]   min_r;
    logic [LAT_W-1:0]   max_r;
    logic [SUM_W-1:0]   sum_r;
    logic               timeout_err_r;

    logic [LAT_W-1:0]   timer_inc;
    logic               tmo_hit;
    logic               last_run;
    logic [SUM_W-1:0]   sum_next;

    // Wait timer increments but sticks at all ones, so an unbounded wait
    // (timeout = 0) can never wrap around.
    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        if (v == {LAT_W{1'b1}})
            return v;
        else
            return v + LAT_ONE;
    endfunction

    always_comb begin
        timer_inc = sat_inc(timer);
        // Timer is cleared in FIRE, so the n-th WAIT cycle sees timer = n-1;
        // comparing the incremented value fires on exactly the timeout-th cycle.
        tmo_hit   = (timeout_r != '0) && (timer_inc == timeout_r);
        last_run  = ((run_cnt + RUN_ONE) == num_runs_r);
        sum_next  = sum_r + {{RUN_W{1'b0}}, i_lat};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            num_runs_r    <= '0;
            timeout_r     <= '0;
            timer         <= '0;
            run_cnt       <= '0;
            min_r         <= '1;
            max_r         <= '0;
            sum_r         <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_runs_r    <= i_num_runs;
                        timeout_r     <= i_timeout;
                        run_cnt       <= '0;
                        min_r         <= '1;
                        max_r         <= '0;
                        sum_r         <= '0;
                        timeout_err_r <= 1'b0;
                        state         <= (i_num_runs == '0) ? S_DONE : S_CLR;
                    end
                end
                S_CLR: begin
                    state <= S_FIRE;
                end
                S_FIRE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer_inc;
                    // A valid pulse takes priority over a coincident timeout.
                    if (i_lat_valid) begin
                        if (i_lat < min_r) min_r <= i_lat;
                        if (i_lat > max_r) max_r <= i_lat;
                        sum_r   <= sum_next;
                        run_cnt <= run_cnt + RUN_ONE;
                        state   <= last_run ? S_DONE : S_GAP;
                    end else if (tmo_hit) begin
                        timeout_err_r <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                // One idle cycle lets the DUT drop its output-valid so the
                // meter's edge detector re-arms before the next clear.
                S_GAP: begin
                    state <= S_CLR;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (state != S_IDLE);
    assign o_meas_rst    = (state == S_CLR);
    assign o_in_enb      = (state == S_FIRE);
    assign o_done        = (state == S_DONE);
    assign o_timeout_err = timeout_err_r;
    assign o_run_cnt     = run_cnt;
    // Internal min starts at all ones; hide that until something is captured.
    assign o_lat_min     = (run_cnt == '0) ? '0 : min_r;
    assign o_lat_max     = max_r;
    assign o_lat_sum     = sum_r;

endmodule

// File: tb/tb_task_3_lat_meas_ctrl.sv
module tb_task_3_lat_meas_ctrl;

    localparam int DATA_WIDTH        = 8;
    localparam int LAT_SIZE_IN_WIDTH = 3;
    localparam int RUN_W             = 4;
    localparam int LAT_W             = LAT_SIZE_IN_WIDTH * DATA_WIDTH;
    localparam int SUM_W             = LAT_W + RUN_W;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [RUN_W-1:0] i_num_runs = '0;
    logic [LAT_W-1:0] i_timeout = '0;
    logic             o_meas_rst;
    logic             o_in_enb;
    logic             i_lat_valid = 1'b0;
    logic [LAT_W-1:0] i_lat = '0;
    logic             o_busy;
    logic             o_done;
    logic             o_timeout_err;
    logic [RUN_W-1:0] o_run_cnt;
    logic [LAT_W-1:0] o_lat_min;
    logic [LAT_W-1:0] o_lat_max;
    logic [SUM_W-1:0] o_lat_sum;

    task_3_lat_meas_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .LAT_SIZE_IN_WIDTH(LAT_SIZE_IN_WIDTH),
        .RUN_W(RUN_W)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_num_runs(i_num_runs),
        .i_timeout(i_timeout),
        .o_meas_rst(o_meas_rst),
        .o_in_enb(o_in_enb),
        .i_lat_valid(i_lat_valid),
        .i_lat(i_lat),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_timeout_err(o_timeout_err),
        .o_run_cnt(o_run_cnt),
        .o_lat_min(o_lat_min),
        .o_lat_max(o_lat_max),
        .o_lat_sum(o_lat_sum)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int run_cnt;
        int lat_min;
        int lat_max;
        int lat_sum;
        int terr;
        int n_rst;
        int n_enb;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int rc, input int mn, input int mx, input int sm,
                                input int te, input int nr, input int ne);
        exp_t e;
        e.run_cnt = rc; e.lat_min = mn; e.lat_max = mx; e.lat_sum = sm;
        e.terr = te; e.n_rst = nr; e.n_enb = ne;
        return e;
    endfunction

    // Monitor: counts meter pulses per batch and checks statistics on o_done.
    int cnt_rst = 0;
    int cnt_enb = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                cnt_rst = 0;
                cnt_enb = 0;
            end else begin
                if (o_meas_rst) cnt_rst++;
                if (o_in_enb)   cnt_enb++;
                if (o_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("run_cnt",     o_run_cnt,     e.run_cnt);
                        check("lat_min",     o_lat_min,     e.lat_min);
                        check("lat_max",     o_lat_max,     e.lat_max);
                        check("lat_sum",     o_lat_sum,     e.lat_sum);
                        check("timeout_err", o_timeout_err, e.terr);
                        check("meas_rst_pulses", cnt_rst,   e.n_rst);
                        check("in_enb_pulses",   cnt_enb,   e.n_enb);
                    end
                    cnt_rst = 0;
                    cnt_enb = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input int n, input int t);
        @(posedge i_clk); #1;
        i_start    = 1'b1;
        i_num_runs = RUN_W'(n);
        i_timeout  = LAT_W'(t);
        @(posedge i_clk); #1;
        i_start    = 1'b0;
    endtask

    // Returns at the negedge of the FIRE cycle.
    task automatic wait_enb();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge i_clk);
            if (o_in_enb) break;
        end
        if (k == 50) check("wait_in_enb_timeout", 0, 1);
    endtask

    // Meter answer on WAIT cycle d with value lat.
    task automatic meter_reply(input int d, input int lat);
        wait_enb();
        @(posedge i_clk);
        repeat (d - 1) @(posedge i_clk);
        #1;
        i_lat_valid = 1'b1;
        i_lat       = LAT_W'(lat);
        @(posedge i_clk); #1;
        i_lat_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (o_done) break;
        end
        if (k == 200) check("wait_done_timeout", 0, 1);
        @(negedge i_clk);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_busy",     o_busy,        0);
        check("rst_done",     o_done,        0);
        check("rst_meas_rst", o_meas_rst,    0);
        check("rst_in_enb",   o_in_enb,      0);
        check("rst_terr",     o_timeout_err, 0);
        check("rst_run_cnt",  o_run_cnt,     0);
        check("rst_min",      o_lat_min,     0);
        check("rst_max",      o_lat_max,     0);
        check("rst_sum",      o_lat_sum,     0);

        // Three runs, no timeout: 5, 9, 7.
        sb.push_back(mk(3, 5, 9, 21, 0, 3, 3));
        do_start(3, 0);
        @(negedge i_clk);
        check("busy_in_clr", o_busy, 1);
        check("meas_rst_cycle1", o_meas_rst, 1);
        meter_reply(4, 5);
        meter_reply(2, 9);
        meter_reply(6, 7);
        wait_done();

        // Zero runs: straight to done, no meter pulses.
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        do_start(0, 0);
        wait_done();

        // Timeout of 10 with no valid: done follows the 10th WAIT cycle.
        sb.push_back(mk(0, 0, 0, 0, 1, 1, 1));
        do_start(2, 10);
        wait_enb();
        for (k = 1; k < 30; k++) begin
            @(negedge i_clk);
            if (o_done) break;
        end
        check("timeout_done_cycle", k, 11);
        @(negedge i_clk);

        // Valid on the same cycle the timer hits the timeout: valid wins.
        sb.push_back(mk(1, 4, 4, 4, 0, 1, 1));
        do_start(1, 4);
        meter_reply(4, 4);
        wait_done();

        // i_start pulses during WAIT are ignored.
        sb.push_back(mk(2, 3, 6, 9, 0, 2, 2));
        do_start(2, 0);
        wait_enb();
        @(posedge i_clk); #1;
        i_start = 1'b1; i_num_runs = 4'd5; i_timeout = 24'd1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_lat_valid = 1'b1; i_lat = 24'd3;
        @(posedge i_clk); #1;
        i_lat_valid = 1'b0;
        meter_reply(1, 6);
        wait_done();

        // Reset mid-WAIT drops the batch; outputs clear next cycle.
        do_start(3, 0);
        meter_reply(2, 50);
        wait_enb();
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("midrst_busy",    o_busy,     0);
        check("midrst_run_cnt", o_run_cnt,  0);
        check("midrst_sum",     o_lat_sum,  0);
        check("midrst_max",     o_lat_max,  0);
        check("midrst_min",     o_lat_min,  0);
        sb.push_back(mk(1, 12, 12, 12, 0, 1, 1));
        do_start(1, 0);
        meter_reply(3, 12);
        wait_done();

        // Valid held high through GAP/CLR with a changed value: no extra capture.
        sb.push_back(mk(2, 2, 8, 10, 0, 2, 2));
        do_start(2, 0);
        wait_enb();
        repeat (2) @(posedge i_clk);
        #1;
        i_lat_valid = 1'b1; i_lat = 24'd8;
        @(posedge i_clk); #1;
        i_lat = 24'd100;
        wait_enb();
        i_lat_valid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk); #1;
        i_lat_valid = 1'b1; i_lat = 24'd2;
        @(posedge i_clk); #1;
        i_lat_valid = 1'b0;
        wait_done();

        repeat (5) @(negedge i_clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
